blink_sched: RTL and testbench
==============================

# blink_sched

Shared LED blink-pattern scheduler. Two requesters each submit a blink count over a strobe/ack handshake. The block arbitrates round-robin between them and drives one LED through N on/off blinks, timed by an internal integer-divide phase counter, followed by a fixed dark gap. It sits between user logic (button debouncers, status sources) and the board LED, in place of a free-running pulse-per-second blinker.

## Interface
- CLOCK_RATE_HZ, 50_000_000, input clock frequency in Hz.
- PHASE_DIV, 4, phase-length divisor. PHASE_LEN = CLOCK_RATE_HZ/PHASE_DIV cycles (250 ms at defaults). PHASE_LEN must be ≥ 2.
- CW, 4, width of the blink-count fields.
- i_clk  in  1  system clock. Single clock domain.
- i_reset  in  1  reset; synchronous, active-high.
- i_stb0 / i_stb1  in  1  request strobe, requester 0 / 1. Held high with count stable until the matching ack.
- i_cnt0 / i_cnt1  in  CW  blink count N for requester 0 / 1. N = 0 is legal.
- o_ack0 / o_ack1  out  1  one-cycle registered pulse: request accepted.
- o_led  out  1  LED drive; 1 = lit.
- o_busy  out  1  high while a job is in progress (state ≠ IDLE).
- o_owner  out  1  requester index of the current or most recent job.
- o_done  out  1  one-cycle pulse: job complete, block back in IDLE.

## Operation
- States: IDLE, ON, OFF, GAP. All outputs are registered.
- **Phase counter** `phase`, 32 bits:
  - Cleared on every state entry; increments each cycle in ON/OFF/GAP.
  - Phase end: `phase == PHASE_LEN-1` (ON, OFF) or `phase == 2*PHASE_LEN-1` (GAP).
  - Invariant: `phase < 2*PHASE_LEN`.
- **IDLE:**
  - o_led=0, o_busy=0.
  - If any i_stbX is sampled high: grant, latch count into `remain` (CW bits), set o_owner, pulse o_ackX next cycle.
  - Next state is ON if N>0, GAP if N=0.
- **Arbitration:**
  - Only one requester high: that requester wins.
  - Both high: the requester that is not o_owner wins.
  - After reset o_owner=1, so requester 0 wins the first tie.
  - A requests seen outside IDLE is ignored; it stays pending.
- **ON:** o_led=1. At phase end go to OFF.
- **OFF:** o_led=0. At phase end decrement `remain`:
  - If the result is 0, go to GAP.
  - Otherwise go to ON.
  - `remain` never wraps below 0.
- **GAP:** o_led=0 for 2*PHASE_LEN cycles, then go to IDLE with o_done=1 for that first IDLE cycle.
- **Reset:**
  - Values: state=IDLE, phase=0, remain=0, o_led=0, o_busy=0, o_ack0=o_ack1=0, o_done=0, o_owner=1.
  - Reset mid-job aborts the job: no done pulse, and the LED is dark the cycle after reset is sampled.

## Timing
- Request sampled at the end of IDLE cycle t. In cycle t+1: o_ackX=1, o_busy=1, and o_led=1 if N>0.
- The requester may drop i_stbX in t+1. The block is no longer in IDLE then, so a request cannot be accepted twice.
- Each ON and each OFF phase lasts exactly PHASE_LEN cycles. GAP lasts 2*PHASE_LEN cycles.
- Job duration, ack cycle through last GAP cycle inclusive: (2N+2)·PHASE_LEN cycles. o_done follows in the next cycle.
- A new request can be accepted in the same IDLE cycle that o_done is high. Its ack then arrives one cycle after done.
- o_ack0 and o_ack1 are never high in the same cycle. o_ack and o_done are never high in the same cycle.

## Test plan
All cases use CLOCK_RATE_HZ=40, PHASE_DIV=4, so PHASE_LEN=10. Cycle 0 is the cycle in which the stb is sampled.
- Reset held 3 cycles, stbs low → all outputs 0, o_owner=1. Outputs stay idle with no requests.
- i_stb0=1, i_cnt0=2 →
  - o_ack0 at cycle 1; o_led high in cycles 1–10 and 21–30, low in 11–20, 31–40 and 41–60.
  - o_busy high in 1–60; o_done at cycle 61.
- i_stb0 and i_stb1 both high from cycle 0, counts 2 and 1, held until ack → o_ack0 at 1, o_done at 61, o_ack1 at 62, o_owner=1 from 62, second o_done at 62+40=102.
- i_stb1=1, i_cnt1=0 → o_ack1 at cycle 1; o_led never high; o_busy high in 1–20; o_done at 21.
- i_cnt0=2, i_reset asserted in cycle 5 (ON phase) → o_led=0 and o_busy=0 from cycle 6; no o_done ever; the next request is accepted normally.
- i_cnt0=15 (max) → exactly 15 ON pulses of 10 cycles each; o_done at cycle 1+320=321; `remain` ends at 0 with no wrap.

Source files
------------

// File: rtl/blink_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : blink_sched_if
//  Description : Request/acknowledge bundle and LED status outputs of the
//                shared blink scheduler.
//                slave  modport : scheduler side (takes requests, drives LED)
//                master modport : user side (raises requests, observes LED)
//  Signals     : i_stb0/i_stb1  request strobes, held until matching ack
//                i_cnt0/i_cnt1  blink counts (CW bits)
//                o_ack0/o_ack1  one-cycle accept pulses
//                o_led, o_busy, o_owner, o_done  scheduler status
//  Revision    : 1.0  initial release
// ============================================================================
interface blink_sched_if #(
    parameter int CW = 4
);
    logic          i_stb0;
    logic          i_stb1;
    logic [CW-1:0] i_cnt0;
    logic [CW-1:0] i_cnt1;
    logic          o_ack0;
    logic          o_ack1;
    logic          o_led;
    logic          o_busy;
    logic          o_owner;
    logic          o_done;

    modport slave (
        input  i_stb0, i_stb1, i_cnt0, i_cnt1,
        output o_ack0, o_ack1, o_led, o_busy, o_owner, o_done
    );

    modport master (
        output i_stb0, i_stb1, i_cnt0, i_cnt1,
        input  o_ack0, o_ack1, o_led, o_busy, o_owner, o_done
    );
endinterface
`default_nettype wire

// File: rtl/blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : blink_sched
//  Description : Shared LED blink-pattern scheduler. Two requesters submit a
//                blink count N; the block arbitrates round-robin, drives the
//                LED through N on/off blinks of PHASE_LEN cycles each and
//                then holds a dark gap of 2*PHASE_LEN cycles.
//  Ports       : i_clk    system clock
//                i_reset  synchronous active-high reset
//                io_bus   blink_sched_if.slave (strobes, counts, acks,
//                         o_led, o_busy, o_owner, o_done)
//  Revision    : 1.0  initial release
// ============================================================================
module blink_sched #(
    parameter int CLOCK_RATE_HZ = 50_000_000,
    parameter int PHASE_DIV     = 4,
    parameter int CW            = 4
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    blink_sched_if.slave    io_bus
);

    localparam int            c_PHASE_LEN = CLOCK_RATE_HZ / PHASE_DIV;
    localparam logic [31:0]   c_ON_LAST   = 32'(c_PHASE_LEN - 1);
    localparam logic [31:0]   c_GAP_LAST  = 32'(2 * c_PHASE_LEN - 1);
    localparam logic [CW-1:0] c_ONE       = CW'(1);
    localparam logic [CW-1:0] c_ZERO      = '0;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_ON   = 2'd1;
    localparam logic [1:0] c_S_OFF  = 2'd2;
    localparam logic [1:0] c_S_GAP  = 2'd3;

    logic [1:0]    r_state;
    logic [31:0]   r_phase;
    logic [CW-1:0] r_remain;
    logic          r_led;
    logic          r_busy;
    logic          r_owner;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_done;

    logic          w_any_req;
    logic          w_grant1;
    logic [CW-1:0] w_cnt;
    logic          w_on_end;
    logic          w_gap_end;

    // Requester 1 wins when it is alone, or on a tie when requester 0 owned
    // the previous job; otherwise requester 0 wins.
    assign w_any_req = io_bus.i_stb0 | io_bus.i_stb1;
    assign w_grant1  = io_bus.i_stb1 & (~io_bus.i_stb0 | ~r_owner);
    assign w_cnt     = w_grant1 ? io_bus.i_cnt1 : io_bus.i_cnt0;
    assign w_on_end  = (r_phase == c_ON_LAST);
    assign w_gap_end = (r_phase == c_GAP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= c_S_IDLE;
            r_phase  <= '0;
            r_remain <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_owner  <= 1'b1;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                c_S_IDLE: begin
                    r_led  <= 1'b0;
                    r_busy <= 1'b0;
                    r_phase <= '0;
                    if (w_any_req) begin
                        r_owner  <= w_grant1;
                        r_ack0   <= ~w_grant1;
                        r_ack1   <= w_grant1;
                        r_remain <= w_cnt;
                        r_busy   <= 1'b1;
                        // A zero count skips straight to the dark gap.
                        if (w_cnt != c_ZERO) begin
                            r_state <= c_S_ON;
                            r_led   <= 1'b1;
                        end else begin
                            r_state <= c_S_GAP;
                        end
                    end
                end

                c_S_ON: begin
                    if (w_on_end) begin
                        r_state <= c_S_OFF;
                        r_phase <= '0;
                        r_led   <= 1'b0;
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end

                c_S_OFF: begin
                    if (w_on_end) begin
                        r_phase <= '0;
                        // Saturating decrement; remain is at least 1 here in
                        // normal operation.
                        if (r_remain != c_ZERO) begin
                            r_remain <= r_remain - c_ONE;
                        end
                        if (r_remain <= c_ONE) begin
                            r_state <= c_S_GAP;
                        end else begin
                            r_state <= c_S_ON;
                            r_led   <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end

                c_S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= c_S_IDLE;
                        r_phase <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 32'd1;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_phase <= '0;
                    r_led   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.o_led   = r_led;
    assign io_bus.o_busy  = r_busy;
    assign io_bus.o_owner = r_owner;
    assign io_bus.o_ack0  = r_ack0;
    assign io_bus.o_ack1  = r_ack1;
    assign io_bus.o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_blink_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blink_sched
//  Description : Scoreboard bench for blink_sched. A job-level model predicts
//                ack/done events (queued) and per-cycle LED/busy/owner levels;
//                a monitor compares them against the DUT every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blink_sched;

    localparam int c_PL   = 10;     // 40 Hz / 4
    localparam int c_MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blink_sched_if #(.CW(4)) bus ();

    blink_sched #(
        .CLOCK_RATE_HZ (40),
        .PHASE_DIV     (4),
        .CW            (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus.slave)
    );

    // Event kinds: 0 = ack0, 1 = ack1, 2 = done
    typedef struct {
        int ecyc;
        int kind;
    } ev_t;

    ev_t  exp_q[$];
    bit   exp_led   [c_MAXC];
    bit   exp_busy  [c_MAXC];
    bit   exp_owner [c_MAXC];

    int   m_free  = 0;
    int   m_owner = 1;
    bit   pend0 = 0, pend1 = 0;
    logic [3:0] cnt0 = '0, cnt1 = '0;
    bit   rst_req = 1;
    bit   chk_en  = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    task automatic chk(input string name, input int act, input int expv, input int t);
        nchecks++;
        if (act != expv) begin
            nerrors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, t, act, expv);
        end
    endtask

    // Job-level reference: a granted job of N blinks lasts (2N+2)*PL cycles
    // from its ack; the LED is lit in the even PL-long slots of the first
    // 2N*PL cycles.
    task automatic model_step();
        int t;
        int w;
        int n;
        int dur;
        ev_t e;
        ev_t keep[$];
        t = cyc;
        if (rst) begin
            for (int i = t + 1; i < c_MAXC; i++) begin
                exp_led[i]   = 1'b0;
                exp_busy[i]  = 1'b0;
                exp_owner[i] = 1'b1;
            end
            foreach (exp_q[k]) if (exp_q[k].ecyc <= t) keep.push_back(exp_q[k]);
            exp_q   = keep;
            m_owner = 1;
            m_free  = t + 1;
        end else if (t >= m_free && (pend0 || pend1)) begin
            if (pend0 && pend1) w = (m_owner == 1) ? 0 : 1;
            else                w = pend1 ? 1 : 0;
            n   = (w == 1) ? int'(cnt1) : int'(cnt0);
            dur = (2 * n + 2) * c_PL;
            for (int k = 0; k < dur; k++) begin
                if (t + 1 + k < c_MAXC) begin
                    exp_led[t + 1 + k]  = (k < 2 * n * c_PL) && (((k / c_PL) % 2) == 0);
                    exp_busy[t + 1 + k] = 1'b1;
                end
            end
            for (int i = t + 1; i < c_MAXC; i++) exp_owner[i] = w[0];
            e.ecyc = t + 1;       e.kind = w; exp_q.push_back(e);
            e.ecyc = t + 1 + dur; e.kind = 2; exp_q.push_back(e);
            m_free  = t + 1 + dur;
            m_owner = w;
        end
    endtask

    // One clock cycle of stimulus: requesters drop their strobe on ack,
    // then the cycle's inputs are applied and fed to the model.
    task automatic advance();
        @(posedge clk);
        #2;
        if (bus.o_ack0) pend0 = 0;
        if (bus.o_ack1) pend1 = 0;
        rst        = rst_req;
        bus.i_stb0 = pend0;
        bus.i_stb1 = pend1;
        bus.i_cnt0 = cnt0;
        bus.i_cnt1 = cnt1;
        model_step();
    endtask

    task automatic issue(input int idx, input int n);
        if (idx == 0 && !pend0) begin pend0 = 1; cnt0 = 4'(n); end
        if (idx == 1 && !pend1) begin pend1 = 1; cnt1 = 4'(n); end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((pend0 || pend1 || cyc < m_free + 2) && guard < 3000) begin
            advance();
            guard++;
        end
        chk("wait_idle_timeout", (guard >= 3000) ? 1 : 0, 0, cyc);
    endtask

    // Monitor: per-cycle levels plus queued ack/done events.
    always @(negedge clk) begin
        int t;
        bit ev_bits [3];
        ev_t e;
        if (chk_en && cyc < c_MAXC) begin
            t = cyc;
            chk("led",   int'(bus.o_led),   int'(exp_led[t]),   t);
            chk("busy",  int'(bus.o_busy),  int'(exp_busy[t]),  t);
            chk("owner", int'(bus.o_owner), int'(exp_owner[t]), t);
            chk("ack_exclusive", int'(bus.o_ack0 & bus.o_ack1), 0, t);
            ev_bits[0] = bus.o_ack0;
            ev_bits[1] = bus.o_ack1;
            ev_bits[2] = bus.o_done;
            for (int k = 0; k < 3; k++) begin
                if (ev_bits[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event_kind", k, -1, t);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind",  k, e.kind, t);
                        chk("event_cycle", t, e.ecyc, t);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].ecyc < t) begin
                e = exp_q.pop_front();
                chk("missed_event_kind", -1, e.kind, e.ecyc);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < c_MAXC; i++) exp_owner[i] = 1'b1;
        bus.i_stb0 = 1'b0;
        bus.i_stb1 = 1'b0;
        bus.i_cnt0 = '0;
        bus.i_cnt1 = '0;

        // Reset held 3 cycles, then idle with no requests.
        rst_req = 1;
        advance();
        chk_en = 1;
        advance();
        advance();
        rst_req = 0;
        repeat (6) advance();

        // Single request, two blinks.
        issue(0, 2);
        wait_idle();

        // Simultaneous requests: requester 0 wins the first tie.
        issue(0, 2);
        issue(1, 1);
        wait_idle();

        // Zero-count job: LED stays dark, gap only.
        issue(1, 0);
        wait_idle();

        // Reset during the first ON phase aborts the job.
        issue(0, 2);
        advance();
        repeat (4) advance();
        rst_req = 1;
        advance();
        rst_req = 0;
        repeat (3) advance();
        issue(0, 1);
        wait_idle();

        // Maximum count.
        issue(0, 15);
        wait_idle();

        // Randomized traffic, including requests arriving mid-job and resets.
        for (int it = 0; it < 40 && cyc < 7000; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      issue(0, $urandom_range(0, 4));
            else if (r < 7) issue(1, $urandom_range(0, 4));
            else if (r < 9) begin
                issue(0, $urandom_range(0, 4));
                issue(1, $urandom_range(0, 4));
            end else begin
                rst_req = 1;
                advance();
                rst_req = 0;
            end
            repeat ($urandom_range(1, 60)) advance();
        end

        wait_idle();
        repeat (3) advance();
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0, cyc);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
